alu_kontroll_enkoder: RTL and testbench

Registered ALU-control encoder for the 16-bit CPU datapath. It accepts instructions over a valid/ready handshake and decodes each into the 3-bit ALU result-select code consumed by the 8-to-1 result multiplexer, plus operand-B source and register-write flags. A two-entry skid buffer gives one-cycle latency at full throughput with a registered `In_Ready`. A saturating counter tallies rejected (illegal) encodings for debug.

---
 rtl/cpu16_pkg.sv | 55 +++++
 rtl/alu_dekoder.sv | 49 ++++
 rtl/alu_kontroll_enkoder.sv | 106 ++++++++++
 tb/tb_alu_kontroll_enkoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : cpu16_pkg                                                |
// | Purpose  : ALU select codes, opcodes, funct codes, control record   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package cpu16_pkg;

  // Result-select codes, ordered as the 8-to-1 result mux inputs
  localparam logic [2:0] SEL_AND  = 3'b000;
  localparam logic [2:0] SEL_SLTI = 3'b001;
  localparam logic [2:0] SEL_OR   = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b011;
  localparam logic [2:0] SEL_ADD  = 3'b100;
  localparam logic [2:0] SEL_SUB  = 3'b101;
  localparam logic [2:0] SEL_SLL  = 3'b110;
  localparam logic [2:0] SEL_SRA  = 3'b111;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_SLTI = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;

  localparam logic [2:0] FN_AND  = 3'b000;
  localparam logic [2:0] FN_RSVD = 3'b001;
  localparam logic [2:0] FN_OR   = 3'b010;
  localparam logic [2:0] FN_XOR  = 3'b011;
  localparam logic [2:0] FN_ADD  = 3'b100;
  localparam logic [2:0] FN_SUB  = 3'b101;
  localparam logic [2:0] FN_SLL  = 3'b110;
  localparam logic [2:0] FN_SRA  = 3'b111;

  typedef struct packed {
    logic [2:0] sel;
    logic       imm;
    logic       wr;
    logic       ill;
  } ctrl_t;

  localparam ctrl_t CTRL_ILLEGAL = '{sel: SEL_AND, imm: 1'b0, wr: 1'b0, ill: 1'b1};

  function automatic ctrl_t mk_ctrl(logic [2:0] sel, logic imm, logic wr);
    ctrl_t c;
    c.sel = sel;
    c.imm = imm;
    c.wr  = wr;
    c.ill = 1'b0;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dekoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_dekoder                                              |
// | Purpose  : Combinational instruction -> ALU control decode          |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module alu_dekoder
  import cpu16_pkg::*;
(
  input  logic [15:0] i_instr,
  output ctrl_t       o_ctrl
);

  logic [3:0] w_op;
  logic [2:0] w_fn;
  logic       w_unused_bits;

  assign w_op          = i_instr[15:12];
  assign w_fn          = i_instr[2:0];
  assign w_unused_bits = ^i_instr[11:3];

  always_comb begin
    o_ctrl = CTRL_ILLEGAL;
    case (w_op)
      OP_R: begin
        case (w_fn)
          FN_AND:  o_ctrl = mk_ctrl(SEL_AND, 1'b0, 1'b1);
          FN_OR:   o_ctrl = mk_ctrl(SEL_OR,  1'b0, 1'b1);
          FN_XOR:  o_ctrl = mk_ctrl(SEL_XOR, 1'b0, 1'b1);
          FN_ADD:  o_ctrl = mk_ctrl(SEL_ADD, 1'b0, 1'b1);
          FN_SUB:  o_ctrl = mk_ctrl(SEL_SUB, 1'b0, 1'b1);
          FN_SLL:  o_ctrl = mk_ctrl(SEL_SLL, 1'b0, 1'b1);
          FN_SRA:  o_ctrl = mk_ctrl(SEL_SRA, 1'b0, 1'b1);
          default: o_ctrl = CTRL_ILLEGAL;
        endcase
      end
      OP_SLTI: o_ctrl = mk_ctrl(SEL_SLTI, 1'b1, 1'b1);
      OP_ADDI: o_ctrl = mk_ctrl(SEL_ADD,  1'b1, 1'b1);
      OP_SUBI: o_ctrl = mk_ctrl(SEL_SUB,  1'b1, 1'b1);
      // Loads and stores both compute base + offset on the adder
      OP_LW:   o_ctrl = mk_ctrl(SEL_ADD,  1'b1, 1'b1);
      OP_SW:   o_ctrl = mk_ctrl(SEL_ADD,  1'b1, 1'b0);
      OP_BEQ:  o_ctrl = mk_ctrl(SEL_SUB,  1'b0, 1'b0);
      default: o_ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_kontroll_enkoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : alu_kontroll_enkoder                                     |
// | Purpose  : Registered ALU-control encoder, skid buffer, illegal cnt |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module alu_kontroll_enkoder
  import cpu16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [15:0]      In_Instr,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [2:0]       Out_AluSel,
  output logic             Out_ImmSel,
  output logic             Out_RegWrite,
  output logic             Out_Illegal,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [CNT_W-1:0] IllegalCount
);

  ctrl_t            w_dec;
  ctrl_t            r_main;
  ctrl_t            r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic             r_in_rdy;
  logic [CNT_W-1:0] r_cnt;

  ctrl_t            w_main_nxt;
  ctrl_t            w_skid_nxt;
  logic             w_main_vld_nxt;
  logic             w_skid_vld_nxt;
  logic             w_acc;
  logic             w_main_free;

  alu_dekoder u_dek (
    .i_instr (In_Instr),
    .o_ctrl  (w_dec)
  );

  assign w_acc       = In_Valid & r_in_rdy;
  assign w_main_free = ~r_main_vld | Out_Ready;

  // Skid never holds a word while main is empty, so a freed main always
  // takes the skid entry first; acceptance is blocked whenever skid is full.
  always_comb begin
    w_main_nxt     = r_main;
    w_main_vld_nxt = r_main_vld;
    w_skid_nxt     = r_skid;
    w_skid_vld_nxt = r_skid_vld;
    if (w_main_free) begin
      if (r_skid_vld) begin
        w_main_nxt     = r_skid;
        w_main_vld_nxt = 1'b1;
        w_skid_vld_nxt = 1'b0;
      end else begin
        w_main_vld_nxt = w_acc;
        if (w_acc) begin
          w_main_nxt = w_dec;
        end
      end
    end else if (w_acc) begin
      w_skid_nxt     = w_dec;
      w_skid_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b1;
    end else begin
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_in_rdy   <= ~w_skid_vld_nxt;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (w_acc && w_dec.ill && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign In_Ready     = r_in_rdy;
  assign Out_Valid    = r_main_vld;
  assign Out_AluSel   = r_main.sel;
  assign Out_ImmSel   = r_main.imm;
  assign Out_RegWrite = r_main.wr;
  assign Out_Illegal  = r_main.ill;
  assign IllegalCount = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_kontroll_enkoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_alu_kontroll_enkoder                                  |
// | Purpose  : Directed self-checking bench for alu_kontroll_enkoder    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_kontroll_enkoder;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [15:0]      in_instr;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       out_sel;
  logic             out_imm;
  logic             out_wr;
  logic             out_ill;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] ill_cnt;
  logic [5:0]       obs;

  int n_assert = 0;
  int n_fail   = 0;

  alu_kontroll_enkoder #(.CNT_W(CNT_W)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .In_Instr     (in_instr),
    .In_Valid     (in_valid),
    .In_Ready     (in_ready),
    .Out_AluSel   (out_sel),
    .Out_ImmSel   (out_imm),
    .Out_RegWrite (out_wr),
    .Out_Illegal  (out_ill),
    .Out_Valid    (out_valid),
    .Out_Ready    (out_ready),
    .IllegalCount (ill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control packed as {sel, imm, wr, ill}
  assign obs = {out_sel, out_imm, out_wr, out_ill};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed {sel,imm,wr,ill} for each stimulus word
  logic [2:0]  rfn  [7] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [15:0] iw   [6] = '{16'h1000, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000};
  logic [5:0]  ie   [6] = '{6'b001110, 6'b100110, 6'b101110, 6'b100110, 6'b100100, 6'b101000};
  logic [15:0] rw   [20] = '{16'h0000, 16'h0001, 16'h1234, 16'h2000, 16'h4FFF,
                             16'h5ABC, 16'h3000, 16'h600F, 16'h7007, 16'h9000,
                             16'h8123, 16'h0FF7, 16'h0FF9, 16'h0ABA, 16'h0003,
                             16'h0006, 16'h0005, 16'h7FFF, 16'h0004, 16'h1000};
  logic [5:0]  re   [20] = '{6'b000010, 6'b000001, 6'b001110, 6'b000001, 6'b100110,
                             6'b101110, 6'b000001, 6'b100110, 6'b100100, 6'b000001,
                             6'b101000, 6'b111010, 6'b000001, 6'b010010, 6'b011010,
                             6'b110010, 6'b101010, 6'b100100, 6'b100010, 6'b001110};
  logic [5:0]  q [$];

  initial begin
    int idx;
    int rcv;
    int cyc;
    logic acc;
    logic drn;

    rst       = 1'b1;
    in_instr  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl",  obs, 6'b000000);
    chk("rst_cnt",   ill_cnt, 0);
    step();
    chk("rst_ready", in_ready, 1);

    // R-type stream, back-to-back
    for (int i = 0; i < 7; i++) begin
      in_instr = {4'h0, 9'h000, rfn[i]};
      in_valid = 1'b1;
      step();
      chk("r_valid", out_valid, 1);
      chk("r_ctrl",  obs, {rfn[i], 3'b010});
      chk("r_ready", in_ready, 1);
    end

    for (int i = 0; i < 6; i++) begin
      in_instr = iw[i];
      step();
      chk("i_valid", out_valid, 1);
      chk("i_ctrl",  obs, ie[i]);
    end
    in_valid = 1'b0;
    step();
    chk("idle_valid", out_valid, 0);

    // Backpressure: ADD in main, SUB in skid, SLL waits
    out_ready = 1'b0;
    in_instr  = 16'h0004;
    in_valid  = 1'b1;
    step();
    chk("bp_w1",     obs, 6'b100010);
    chk("bp_rdy1",   in_ready, 1);
    in_instr = 16'h0005;
    step();
    chk("bp_hold1",  obs, 6'b100010);
    chk("bp_rdy0",   in_ready, 0);
    in_instr = 16'h0006;
    step();
    chk("bp_hold2",  obs, 6'b100010);
    chk("bp_rdy0b",  in_ready, 0);
    chk("bp_vld",    out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("bp_w2",     obs, 6'b101010);
    chk("bp_rdy_up", in_ready, 1);
    step();
    chk("bp_w3",     obs, 6'b110010);
    chk("bp_w3_vld", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_empty",  out_valid, 0);

    // Illegal words and counter
    chk("cnt0", ill_cnt, 0);
    in_instr = 16'h0001;
    in_valid = 1'b1;
    step();
    chk("ill1_ctrl", obs, 6'b000001);
    chk("cnt1",      ill_cnt, 1);
    in_instr = 16'hF000;
    step();
    chk("ill2_ctrl", obs, 6'b000001);
    chk("cnt2",      ill_cnt, 2);
    in_valid = 1'b0;
    step();

    // Reset with both entries full
    out_ready = 1'b0;
    in_instr  = 16'h0004;
    in_valid  = 1'b1;
    step();
    in_instr = 16'h0005;
    step();
    chk("full_rdy", in_ready, 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ctrl",  obs, 6'b000000);
    chk("mrst_cnt",   ill_cnt, 0);
    chk("mrst_rdy",   in_ready, 1);
    @(negedge clk);
    rst      = 1'b0;
    in_instr = 16'h4000;
    in_valid = 1'b1;
    step();
    chk("post_rst_ctrl",  obs, 6'b100110);
    chk("post_rst_valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("no_replay", out_valid, 0);

    // Random handshakes against a scoreboard
    idx = 0;
    rcv = 0;
    cyc = 0;
    while ((rcv < 20) && (cyc < 2000)) begin
      in_valid  = (idx < 20) && ($urandom_range(0, 2) != 0);
      in_instr  = (idx < 20) ? rw[idx] : 16'h0000;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn) begin
        if (q.size() == 0) begin
          chk("sb_spurious", 1, 0);
        end else begin
          chk("sb_word", obs, q.pop_front());
        end
        rcv++;
      end
      if (acc) begin
        q.push_back(re[idx]);
        idx++;
      end
      step();
      cyc++;
    end
    chk("sb_timeout", (cyc < 2000), 1);
    chk("sb_rcv",     rcv, 20);
    chk("sb_left",    q.size(), 0);
    chk("sat_cnt",    ill_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
